uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/cocolink_pkg.sv | 20 ++
 rtl/uart_tx_framer_baud_tick.sv | 29 ++
 rtl/uart_tx_framer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cocolink_pkg.sv
// Shared FSM encoding, frame constants and line levels for the cocolink UART transmitter.
package cocolink_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_framer_baud_tick.sv
// Bit-period counter: counts 0..DIVISOR-1 and pulses tick on the last count of each bit.
module baud_tick #(
    parameter int DIVISOR   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIVISOR - 1);

    logic [CNT_WIDTH-1:0] count;

    assign tick = (count == LAST);

    // Wrapping on tick keeps every bit exactly DIVISOR cycles long.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmit framer; define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Handshake: a byte is accepted on a rising edge with valid=1 and ready=1; ready is high only in IDLE.
module uart_tx_framer
    import cocolink_pkg::*;
#(
    parameter int DIVISOR   = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy,
    output logic [2:0] fsm_state
);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           bit_idx;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign ready     = (state == ST_IDLE);
    assign busy      = ~ready;
    assign fsm_state = state;

    // Held clear through IDLE, so the counter starts from zero on the accept edge.
    baud_tick #(
        .DIVISOR   (DIVISOR),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_baud_tick (
        .clock (clock),
        .reset (reset),
        .clear (ready),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            txd     <= LINE_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        state   <= ST_START;
                        txd     <= LINE_START;
                        shreg   <= data;
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        parity  <= even_parity(data);
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        txd   <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd   <= parity;
`else
                            state <= ST_STOP;
                            txd   <= LINE_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        txd   <= LINE_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        txd   <= LINE_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule
